// File: rtl/bitrev_reorder_buf_if.sv
// Stream bundle for the bit-reverse reorder buffer: write-side and read-side
// valid/ready handshakes with their data, plus the end-of-frame marker.
interface bitrev_reorder_buf_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/bitrev_reorder_buf.sv
// Multi-bank frame buffer: writes land at bit-reversed (or natural) addresses,
// reads stream sequentially through a 1-cycle memory and a 2-entry skid buffer.
module bitrev_reorder_buf #(
   parameter  int DATA_WIDTH = 32,
   parameter  int MAX_POINT  = 64,
   parameter  int NUM_BANKS  = 2,
   localparam int LOGN       = $clog2(MAX_POINT),
   localparam int PW         = $clog2(LOGN + 1),
   localparam int CW         = $clog2(NUM_BANKS + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [PW-1:0]        point,
   input  logic                 bitrev_en,
   bitrev_reorder_buf_if.slave  stream,
   output logic                 frame_done,
   output logic                 err_point,
   output logic [CW-1:0]        banks_full
);

   localparam int BW = $clog2(NUM_BANKS);

   typedef enum logic [1:0] {FREE, FILLING, FULL, DRAINING} bank_state_t;

   bank_state_t           state_q  [NUM_BANKS];
   bank_state_t           state_d  [NUM_BANKS];
   logic [PW-1:0]         bank_pt  [NUM_BANKS];
   logic                  bank_rev [NUM_BANKS];
   logic [DATA_WIDTH-1:0] mem      [NUM_BANKS][MAX_POINT];

   logic [BW-1:0]         wr_ptr, rd_ptr, out_ptr;
   logic [LOGN-1:0]       wr_cnt, rd_cnt, wr_max, rd_max, k_rev, wr_addr;
   logic [PW-1:0]         pt_eff, wr_pt;
   logic                  pt_bad, wr_rev, ready_en;
   logic                  wr_first, wr_fire, wr_last, rd_issue, rd_last, pop, pop_last;
   logic [2:0]            occ;
   logic                  rd_vld, rd_vld_last;
   logic [DATA_WIDTH-1:0] rd_data;
   logic [DATA_WIDTH-1:0] sk_data [2];
   logic                  sk_last [2];
   logic [1:0]            sk_cnt;
   logic [CW-1:0]         full_cnt;

   function automatic logic [BW-1:0] next_ptr(input logic [BW-1:0] p);
      return (p == BW'(NUM_BANKS - 1)) ? '0 : p + BW'(1);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < NUM_BANKS; b++) state_q[b] <= FREE;
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) state_q[b] <= state_d[b];
      end
   end

   always_comb begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         state_d[b] = state_q[b];
         if (wr_fire && wr_ptr == BW'(b))
            state_d[b] = wr_last ? FULL : FILLING;
         if (rd_issue && rd_ptr == BW'(b) && state_q[b] == FULL)
            state_d[b] = DRAINING;
         if (pop_last && out_ptr == BW'(b))
            state_d[b] = FREE;
      end
   end

   // A bank's first write uses the live point/bitrev_en; later writes use the latched copy.
   // Read issue is throttled so the skid buffer, after this cycle's pop, never exceeds 2.
   always_comb begin
      pt_bad           = (point < PW'(2)) || (point > PW'(LOGN));
      pt_eff           = pt_bad ? PW'(LOGN) : point;
      wr_first         = (state_q[wr_ptr] == FREE);
      wr_pt            = wr_first ? pt_eff : bank_pt[wr_ptr];
      wr_rev           = wr_first ? bitrev_en : bank_rev[wr_ptr];
      wr_max           = LOGN'((1 << wr_pt) - 1);
      rd_max           = LOGN'((1 << bank_pt[rd_ptr]) - 1);
      wr_last          = (wr_cnt == wr_max);
      rd_last          = (rd_cnt == rd_max);
      for (int i = 0; i < LOGN; i++) k_rev[i] = wr_cnt[LOGN-1-i];
      wr_addr          = wr_rev ? (k_rev >> (PW'(LOGN) - wr_pt)) : wr_cnt;
      stream.in_ready  = ready_en &&
                         (state_q[wr_ptr] == FREE || state_q[wr_ptr] == FILLING);
      wr_fire          = stream.in_valid && stream.in_ready;
      pop              = (sk_cnt != 2'd0) && stream.out_ready;
      pop_last         = pop && sk_last[0];
      occ              = {1'b0, sk_cnt} + {2'b0, rd_vld} - {2'b0, pop};
      rd_issue         = ((state_q[rd_ptr] == FULL) ||
                          (state_q[rd_ptr] == DRAINING && rd_cnt != '0)) && (occ <= 3'd1);
      stream.out_valid = (sk_cnt != 2'd0);
      stream.out_data  = stream.out_valid ? sk_data[0] : '0;
      stream.out_last  = stream.out_valid && sk_last[0];
      frame_done       = pop_last;
   end

   always_comb begin
      full_cnt = '0;
      for (int b = 0; b < NUM_BANKS; b++)
         if (state_q[b] == FULL || state_q[b] == DRAINING) full_cnt = full_cnt + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (wr_fire) mem[wr_ptr][wr_addr] <= stream.in_data;
      rd_data <= mem[rd_ptr][rd_cnt];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         wr_cnt    <= '0;
         err_point <= 1'b0;
         ready_en  <= 1'b0;
         for (int b = 0; b < NUM_BANKS; b++) begin
            bank_pt[b]  <= PW'(LOGN);
            bank_rev[b] <= 1'b0;
         end
      end else begin
         ready_en  <= 1'b1;
         err_point <= wr_fire && wr_first && pt_bad;
         if (wr_fire) begin
            if (wr_first) begin
               bank_pt[wr_ptr]  <= pt_eff;
               bank_rev[wr_ptr] <= bitrev_en;
            end
            if (wr_last) begin
               wr_cnt <= '0;
               wr_ptr <= next_ptr(wr_ptr);
            end else begin
               wr_cnt <= wr_cnt + LOGN'(1);
            end
         end
      end
   end

   // out_ptr trails rd_ptr so a bank is only freed once its last sample leaves the skid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr      <= '0;
         rd_cnt      <= '0;
         out_ptr     <= '0;
         rd_vld      <= 1'b0;
         rd_vld_last <= 1'b0;
         sk_cnt      <= 2'd0;
         sk_data[0]  <= '0;
         sk_data[1]  <= '0;
         sk_last[0]  <= 1'b0;
         sk_last[1]  <= 1'b0;
         banks_full  <= '0;
      end else begin
         banks_full  <= full_cnt;
         rd_vld      <= rd_issue;
         rd_vld_last <= rd_issue && rd_last;
         if (rd_issue) begin
            if (rd_last) begin
               rd_cnt <= '0;
               rd_ptr <= next_ptr(rd_ptr);
            end else begin
               rd_cnt <= rd_cnt + LOGN'(1);
            end
         end
         if (pop_last) out_ptr <= next_ptr(out_ptr);
         case ({rd_vld, pop})
            2'b10: begin
               if (sk_cnt == 2'd0) begin
                  sk_data[0] <= rd_data;
                  sk_last[0] <= rd_vld_last;
               end else begin
                  sk_data[1] <= rd_data;
                  sk_last[1] <= rd_vld_last;
               end
               sk_cnt <= sk_cnt + 2'd1;
            end
            2'b01: begin
               sk_data[0] <= sk_data[1];
               sk_last[0] <= sk_last[1];
               sk_cnt     <= sk_cnt - 2'd1;
            end
            2'b11: begin
               if (sk_cnt == 2'd1) begin
                  sk_data[0] <= rd_data;
                  sk_last[0] <= rd_vld_last;
               end else begin
                  sk_data[0] <= sk_data[1];
                  sk_last[0] <= sk_last[1];
                  sk_data[1] <= rd_data;
                  sk_last[1] <= rd_vld_last;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
